data_sync_hs: RTL and testbench
===============================

// Module: data_sync_hs
// PURPOSE
//  Destination-domain synchronizer for a multi-bit bus crossing from another clock domain.
//  Successor to the 2-flop enable-synchronized bus capture: selectable level/toggle enable,
//  toggle ack back to source, DEPTH-entry FWFT buffer with valid/ready, overrun flag.
//  Sits at the receive edge of any CDC path (e.g. UART RX data -> system clock domain).
// PARAMETERS
//  NUM_Stages  2  enable synchronizer depth; legal >= 2
//  Width       8  data bus width; legal >= 1
//  DEPTH       4  buffer entries; power of 2, legal >= 2
//  EN_MODE     0  0 = LEVEL (event on synced rising edge), 1 = TOGGLE (event on any synced edge)
// PORTS
//  CLK        in   1      destination clock
//  Reset      in   1      asynchronous, active-low reset
//  Async_bus  in   Width  source data; held stable by source from bus_EN change until capture
//  bus_EN     in   1      source enable (level or toggle per EN_MODE), asynchronous
//  ack_out    out  1      toggles once per accepted capture; returned to source domain
//  sync_bus   out  Width  buffer head (FWFT); meaningful only while sync_valid=1
//  sync_valid out  1      buffer not empty
//  sync_ready in   1      consumer pops head when sync_valid & sync_ready at CLK rise
//  EN_pulse   out  1      one-cycle pulse the cycle after each accepted capture
//  overrun    out  1      one-cycle pulse: LEVEL-mode event dropped because buffer full
// BEHAVIOUR
//  Reset (Reset=0, async): sync chain, edge FF, pending, pointers, count, all entries = 0;
//   ack_out=0, sync_valid=0, sync_bus=0, EN_pulse=0, overrun=0.
//  Sync: bus_EN -> NUM_Stages flops -> s; edge FF e <= s each cycle.
//   LEVEL event = s & ~e; TOGGLE event = s ^ e (combinational).
//  Accept condition: can_wr = (count < DEPTH) | (sync_valid & sync_ready).
//  Latency: bus_EN change sampled at edge 1; event high after edge NUM_Stages; if can_wr,
//   at edge NUM_Stages+1: Async_bus written, count++, ack_out toggles, EN_pulse=1 one cycle,
//   sync_valid=1 (if buffer was empty).
//  TOGGLE mode, event & !can_wr: set pending; capture taken on first cycle can_wr=1
//   (pending cleared, ack toggled, EN_pulse); no data lost, no overrun. Source must not
//   toggle again before ack. Further event while pending: not representable (protocol error).
//  LEVEL mode, event & !can_wr: data dropped, overrun=1 one cycle, ack_out unchanged.
//  Simultaneous push+pop: count unchanged, both pointers advance; legal at full.
//  Pop only: count--, rd_ptr++ (wraps mod DEPTH). Push only: wr_ptr++ (wraps mod DEPTH).
//  sync_bus = mem[rd_ptr] combinationally; ready ignored while sync_valid=0.
//  Post-reset: bus_EN=1 already held counts as one event (chain resets to 0) in both modes.
//  Reset mid-operation: buffered data and pending capture discarded; source must also reset
//   its toggle state.
//  Only bus_EN is synchronized; Async_bus sampled directly, relying on source stability.
// STRUCTURE
//  data_sync_pkg: EN_MODE_LEVEL=0, EN_MODE_TOGGLE=1 constants; ptr width function.
//  Sub-module bit_sync (NUM_Stages flop chain, async active-low reset) for bus_EN;
//   buffer, pending and ack logic inline.
// TESTING
//  1 LEVEL, NUM_Stages=2: Async_bus=8'hA5, bus_EN 0->1 -> sync_valid,EN_pulse high after
//    edge 3, sync_bus=8'hA5, ack_out 0->1; holding bus_EN=1 gives no second capture.
//  2 TOGGLE: bus_EN 0->1 (8'h11) then after ack 1->0 (8'h22), sync_ready=0 -> two entries,
//    pops give 8'h11 then 8'h22, ack_out toggled twice.
//  3 LEVEL, DEPTH=4, sync_ready=0: 5 pulses 8'h01..8'h05 -> 4 stored, 5th: overrun pulse,
//    ack unchanged; pops 8'h01..8'h04.
//  4 TOGGLE full + 5th toggle (8'h05), sync_ready=1 later -> pending, captured in pop
//    cycle, ack toggles then, no overrun, 8'h05 last out.
//  5 Full buffer, event and pop same cycle -> count stays 4, data order preserved across
//    pointer wrap (8 pushes total).
//  6 Reset=0 mid-stream with 3 entries -> sync_valid=0, ack_out=0 immediately; bus_EN held 1
//    after release -> exactly one capture.

Source files
------------

// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the destination-domain bus synchronizer.
package data_sync_pkg;

  localparam int EN_MODE_LEVEL  = 0;
  localparam int EN_MODE_TOGGLE = 1;

  // Index width for a power-of-two buffer; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/data_sync_hs_if.sv
// Source-side and consumer-side signals of the synchronizer, bundled as one interface.
interface data_sync_hs_if #(
  parameter int Width = 8
);

  logic [Width-1:0] Async_bus;
  logic             bus_EN;
  logic             ack_out;
  logic [Width-1:0] sync_bus;
  logic             sync_valid;
  logic             sync_ready;
  logic             EN_pulse;
  logic             overrun;

  // Environment side: drives source data/enable and consumer ready.
  modport master (
    output Async_bus, bus_EN, sync_ready,
    input  ack_out, sync_bus, sync_valid, EN_pulse, overrun
  );

  // Synchronizer side.
  modport slave (
    input  Async_bus, bus_EN, sync_ready,
    output ack_out, sync_bus, sync_valid, EN_pulse, overrun
  );

endinterface

// File: rtl/data_sync_hs_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous control bit.
module bit_sync #(
  parameter int NUM_Stages = 2
) (
  input  logic CLK,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic [NUM_Stages-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, regardless of statement order.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[NUM_Stages-2:0], d};
    end
  end

  assign q = chain[NUM_Stages-1];

endmodule

// File: rtl/data_sync_hs.sv
// Destination-domain bus synchronizer: synced enable, toggle ack to the source,
// first-word-fall-through buffer with valid/ready and a level-mode overrun pulse.
module data_sync_hs
  import data_sync_pkg::*;
#(
  parameter int NUM_Stages = 2,
  parameter int Width      = 8,
  parameter int DEPTH      = 4,
  parameter int EN_MODE    = EN_MODE_LEVEL
) (
  input logic           CLK,
  input logic           Reset,
  data_sync_hs_if.slave bus
);

  localparam int               PTR_W     = ptr_width(DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam bit               IS_TOGGLE = (EN_MODE == EN_MODE_TOGGLE);

  logic             en_s;
  logic             en_e;
  logic             evt;
  logic             pending;
  logic             ack_q;
  logic             en_pulse_q;
  logic             overrun_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [Width-1:0] mem [DEPTH];

  logic             valid;
  logic             full;
  logic             pop;
  logic             can_wr;
  logic             push;
  logic             set_pending;
  logic             drop;

  bit_sync #(
    .NUM_Stages(NUM_Stages)
  ) u_en_sync (
    .CLK  (CLK),
    .Reset(Reset),
    .d    (bus.bus_EN),
    .q    (en_s)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      en_e <= 1'b0;
    end else begin
      en_e <= en_s;
    end
  end

  // NOTE: every signal gets a value on every pass through always_comb; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    evt         = IS_TOGGLE ? (en_s ^ en_e) : (en_s & ~en_e);
    valid       = (count != '0);
    full        = (count == FULL_CNT);
    pop         = valid & bus.sync_ready;
    // A pop in the same cycle frees the slot the push needs, even at full.
    can_wr      = ~full | pop;
    push        = (evt | pending) & can_wr;
    set_pending = IS_TOGGLE & evt & ~can_wr;
    drop        = ~IS_TOGGLE & evt & ~can_wr;
  end

  // Toggle mode defers a blocked capture; the source holds its data until ack.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pending <= 1'b0;
    end else if (push) begin
      pending <= 1'b0;
    end else if (set_pending) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ack_q      <= 1'b0;
      en_pulse_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      en_pulse_q <= push;
      overrun_q  <= drop;
      if (push) begin
        ack_q <= ~ack_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is reset so the head reads zero out of reset;
  // this keeps it in flops rather than a RAM macro, which is fine at this depth.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= bus.Async_bus;
    end
  end

  assign bus.ack_out    = ack_q;
  assign bus.sync_valid = valid;
  assign bus.sync_bus   = mem[rd_ptr];
  assign bus.EN_pulse   = en_pulse_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_data_sync_hs.sv
// Bench for data_sync_hs: one LEVEL and one TOGGLE instance checked against a queue model.
module tb_data_sync_hs;
  import data_sync_pkg::*;

  localparam int NS = 2;
  localparam int W  = 8;
  localparam int D  = 4;

  logic CLK   = 1'b0;
  logic Reset = 1'b0;

  data_sync_hs_if #(.Width(W)) lif ();
  data_sync_hs_if #(.Width(W)) tif ();

  data_sync_hs #(
    .NUM_Stages(NS), .Width(W), .DEPTH(D), .EN_MODE(EN_MODE_LEVEL)
  ) u_lvl (
    .CLK(CLK), .Reset(Reset), .bus(lif)
  );

  data_sync_hs #(
    .NUM_Stages(NS), .Width(W), .DEPTH(D), .EN_MODE(EN_MODE_TOGGLE)
  ) u_tgl (
    .CLK(CLK), .Reset(Reset), .bus(tif)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expected buffer contents, ack level and deferred capture.
  logic [W-1:0] l_q[$];
  logic [W-1:0] t_q[$];
  logic         l_ack = 1'b0;
  logic         t_ack = 1'b0;
  bit           t_pend = 1'b0;
  logic [W-1:0] t_pend_data = '0;

  int l_pulse_cnt = 0;
  int l_ovr_cnt   = 0;
  int t_pulse_cnt = 0;
  int t_ovr_cnt   = 0;

  always @(negedge CLK) begin
    if (lif.EN_pulse === 1'b1) l_pulse_cnt++;
    if (lif.overrun  === 1'b1) l_ovr_cnt++;
    if (tif.EN_pulse === 1'b1) t_pulse_cnt++;
    if (tif.overrun  === 1'b1) t_ovr_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic level_send(input logic [W-1:0] data, input bit pop_same);
    bit do_pop;
    bit accept;
    lif.Async_bus = data;
    lif.bus_EN    = 1'b1;
    repeat (NS) tick();
    n_checks++;
    if (lif.ack_out !== l_ack || lif.EN_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL lvl_latency: ack=%b pulse=%b, want ack=%b pulse=0", lif.ack_out, lif.EN_pulse, l_ack);
    end
    lif.bus_EN = 1'b0;
    do_pop = pop_same && (l_q.size() > 0);
    if (do_pop) begin
      n_checks++;
      if (lif.sync_valid !== 1'b1 || lif.sync_bus !== l_q[0]) begin
        n_errors++;
        $display("FAIL lvl_pop_same_head: valid=%b bus=%h, want 1 %h", lif.sync_valid, lif.sync_bus, l_q[0]);
      end
      lif.sync_ready = 1'b1;
    end
    tick();
    lif.sync_ready = 1'b0;
    if (do_pop) void'(l_q.pop_front());
    accept = (l_q.size() < D);
    if (accept) begin
      l_q.push_back(data);
      l_ack = ~l_ack;
    end
    n_checks++;
    if ({lif.EN_pulse, lif.overrun, lif.ack_out} !== {accept, ~accept, l_ack}) begin
      n_errors++;
      $display("FAIL lvl_capture: pulse/ovr/ack=%b%b%b, want %b%b%b",
               lif.EN_pulse, lif.overrun, lif.ack_out, accept, ~accept, l_ack);
    end
    n_checks++;
    if (lif.sync_valid !== 1'b1 || lif.sync_bus !== l_q[0]) begin
      n_errors++;
      $display("FAIL lvl_head: valid=%b bus=%h, want 1 %h", lif.sync_valid, lif.sync_bus, l_q[0]);
    end
    tick();
  endtask

  task automatic pop_level();
    bit had;
    had = (l_q.size() > 0);
    if (had) begin
      n_checks++;
      if (lif.sync_valid !== 1'b1 || lif.sync_bus !== l_q[0]) begin
        n_errors++;
        $display("FAIL lvl_pop_data: valid=%b bus=%h, want 1 %h", lif.sync_valid, lif.sync_bus, l_q[0]);
      end
    end
    lif.sync_ready = 1'b1;
    tick();
    lif.sync_ready = 1'b0;
    if (had) void'(l_q.pop_front());
    n_checks++;
    if (lif.sync_valid !== (l_q.size() > 0) || lif.ack_out !== l_ack || lif.EN_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL lvl_pop_state: valid=%b ack=%b pulse=%b, want %b %b 0",
               lif.sync_valid, lif.ack_out, lif.EN_pulse, (l_q.size() > 0), l_ack);
    end
  endtask

  task automatic toggle_send(input logic [W-1:0] data);
    bit accept;
    tif.Async_bus = data;
    tif.bus_EN    = ~tif.bus_EN;
    repeat (NS) tick();
    n_checks++;
    if (tif.ack_out !== t_ack || tif.EN_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL tgl_latency: ack=%b pulse=%b, want ack=%b pulse=0", tif.ack_out, tif.EN_pulse, t_ack);
    end
    tick();
    accept = (t_q.size() < D);
    if (accept) begin
      t_q.push_back(data);
      t_ack = ~t_ack;
    end else begin
      t_pend      = 1'b1;
      t_pend_data = data;
    end
    n_checks++;
    if ({tif.EN_pulse, tif.overrun, tif.ack_out} !== {accept, 1'b0, t_ack}) begin
      n_errors++;
      $display("FAIL tgl_capture: pulse/ovr/ack=%b%b%b, want %b0%b",
               tif.EN_pulse, tif.overrun, tif.ack_out, accept, t_ack);
    end
    n_checks++;
    if (tif.sync_valid !== 1'b1 || tif.sync_bus !== t_q[0]) begin
      n_errors++;
      $display("FAIL tgl_head: valid=%b bus=%h, want 1 %h", tif.sync_valid, tif.sync_bus, t_q[0]);
    end
    tick();
  endtask

  task automatic pop_toggle();
    bit had;
    bit cap;
    had = (t_q.size() > 0);
    if (had) begin
      n_checks++;
      if (tif.sync_valid !== 1'b1 || tif.sync_bus !== t_q[0]) begin
        n_errors++;
        $display("FAIL tgl_pop_data: valid=%b bus=%h, want 1 %h", tif.sync_valid, tif.sync_bus, t_q[0]);
      end
    end
    tif.sync_ready = 1'b1;
    tick();
    tif.sync_ready = 1'b0;
    if (had) void'(t_q.pop_front());
    // A deferred capture lands in the cycle the pop frees a slot.
    cap = t_pend && had;
    if (cap) begin
      t_q.push_back(t_pend_data);
      t_ack  = ~t_ack;
      t_pend = 1'b0;
    end
    n_checks++;
    if ({tif.EN_pulse, tif.overrun, tif.ack_out, tif.sync_valid} !== {cap, 1'b0, t_ack, (t_q.size() > 0)}) begin
      n_errors++;
      $display("FAIL tgl_pop_state: pulse/ovr/ack/valid=%b%b%b%b, want %b0%b%b",
               tif.EN_pulse, tif.overrun, tif.ack_out, tif.sync_valid, cap, t_ack, (t_q.size() > 0));
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({lif.ack_out, lif.sync_valid, lif.EN_pulse, lif.overrun, lif.sync_bus} !== '0) begin
      n_errors++;
      $display("FAIL reset_lvl: ack/valid/pulse/ovr=%b%b%b%b bus=%h, want all 0",
               lif.ack_out, lif.sync_valid, lif.EN_pulse, lif.overrun, lif.sync_bus);
    end
    n_checks++;
    if ({tif.ack_out, tif.sync_valid, tif.EN_pulse, tif.overrun, tif.sync_bus} !== '0) begin
      n_errors++;
      $display("FAIL reset_tgl: ack/valid/pulse/ovr=%b%b%b%b bus=%h, want all 0",
               tif.ack_out, tif.sync_valid, tif.EN_pulse, tif.overrun, tif.sync_bus);
    end
    #2 Reset = 1'b1;
    repeat (NS + 2) tick();
    n_checks++;
    if ({lif.ack_out, lif.sync_valid, tif.ack_out, tif.sync_valid} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_release_idle: lvl ack/valid=%b%b tgl ack/valid=%b%b, want 0000",
               lif.ack_out, lif.sync_valid, tif.ack_out, tif.sync_valid);
    end
  endtask

  task automatic test_level_capture();
    int p0;
    p0 = l_pulse_cnt;
    lif.Async_bus = 8'hA5;
    lif.bus_EN    = 1'b1;
    repeat (NS) tick();
    n_checks++;
    if ({lif.sync_valid, lif.EN_pulse, lif.ack_out} !== 3'b000) begin
      n_errors++;
      $display("FAIL lvl1_early: valid/pulse/ack=%b%b%b, want 000", lif.sync_valid, lif.EN_pulse, lif.ack_out);
    end
    tick();
    l_q.push_back(8'hA5);
    l_ack = ~l_ack;
    n_checks++;
    if ({lif.sync_valid, lif.EN_pulse, lif.ack_out} !== {2'b11, l_ack} || lif.sync_bus !== 8'hA5) begin
      n_errors++;
      $display("FAIL lvl1_capture: valid/pulse/ack=%b%b%b bus=%h, want 11%b a5",
               lif.sync_valid, lif.EN_pulse, lif.ack_out, lif.sync_bus, l_ack);
    end
    repeat (6) tick();
    n_checks++;
    if ((l_pulse_cnt - p0) != 1 || lif.ack_out !== l_ack || lif.sync_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL lvl1_hold: pulses=%0d ack=%b valid=%b, want 1 %b 1",
               l_pulse_cnt - p0, lif.ack_out, lif.sync_valid, l_ack);
    end
    lif.bus_EN = 1'b0;
    repeat (NS + 1) tick();
    pop_level();
  endtask

  task automatic test_toggle_two();
    toggle_send(8'h11);
    toggle_send(8'h22);
    n_checks++;
    if (tif.ack_out !== 1'b0 || t_q.size() != 2) begin
      n_errors++;
      $display("FAIL tgl2_ack: ack=%b model_size=%0d, want 0 2", tif.ack_out, t_q.size());
    end
    n_checks++;
    if (tif.sync_bus !== 8'h11) begin
      n_errors++;
      $display("FAIL tgl2_first: bus=%h, want 11", tif.sync_bus);
    end
    pop_toggle();
    n_checks++;
    if (tif.sync_bus !== 8'h22) begin
      n_errors++;
      $display("FAIL tgl2_second: bus=%h, want 22", tif.sync_bus);
    end
    pop_toggle();
  endtask

  task automatic test_level_overrun();
    int o0;
    o0 = l_ovr_cnt;
    for (int i = 1; i <= 5; i++) level_send(W'(i), 1'b0);
    n_checks++;
    if ((l_ovr_cnt - o0) != 1 || lif.ack_out !== l_ack) begin
      n_errors++;
      $display("FAIL lvl_ovr_count: overruns=%0d ack=%b, want 1 %b", l_ovr_cnt - o0, lif.ack_out, l_ack);
    end
    repeat (4) pop_level();
  endtask

  task automatic test_toggle_pending();
    int o0;
    int p0;
    o0 = t_ovr_cnt;
    for (int i = 1; i <= 4; i++) toggle_send(W'(i));
    p0 = t_pulse_cnt;
    toggle_send(8'h05);
    repeat (3) tick();
    n_checks++;
    if (tif.ack_out !== t_ack || t_pulse_cnt != p0 || t_pend != 1'b1) begin
      n_errors++;
      $display("FAIL tgl_pend_wait: ack=%b pulses=%0d, want %b 0", tif.ack_out, t_pulse_cnt - p0, t_ack);
    end
    repeat (5) pop_toggle();
    n_checks++;
    if (t_ovr_cnt != o0 || tif.sync_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL tgl_pend_end: overruns=%0d valid=%b, want 0 0", t_ovr_cnt - o0, tif.sync_valid);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 3; i++) level_send(W'($urandom), 1'b0);
    repeat (3) pop_level();
    for (int i = 0; i < 4; i++) level_send(W'($urandom), 1'b0);
    level_send(W'($urandom), 1'b1);
    // Buffer must still be full: one more event is dropped.
    level_send(W'($urandom), 1'b0);
    repeat (4) pop_level();
    n_checks++;
    if (lif.sync_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL full_pp_drain: valid=%b, want 0", lif.sync_valid);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      if (r < 2) level_send(W'($urandom), r == 1);
      else       pop_level();
    end
    for (int i = 0; i < 40; i++) begin
      if (t_pend || $urandom_range(0, 2) == 0) pop_toggle();
      else                                     toggle_send(W'($urandom));
    end
  endtask

  task automatic test_reset_mid_stream();
    int lp0;
    int tp0;
    while (l_q.size() > 0) pop_level();
    while (t_q.size() > 0) pop_toggle();
    for (int i = 0; i < 3; i++) level_send(W'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) toggle_send(W'($urandom));
    #2 Reset = 1'b0;
    #1;
    n_checks++;
    if ({lif.sync_valid, lif.ack_out, tif.sync_valid, tif.ack_out} !== 4'b0000) begin
      n_errors++;
      $display("FAIL mid_reset: lvl valid/ack=%b%b tgl valid/ack=%b%b, want 0000",
               lif.sync_valid, lif.ack_out, tif.sync_valid, tif.ack_out);
    end
    l_q.delete();
    t_q.delete();
    l_ack  = 1'b0;
    t_ack  = 1'b0;
    t_pend = 1'b0;
    lif.Async_bus = 8'h3C;
    lif.bus_EN    = 1'b1;
    tif.Async_bus = 8'hC3;
    tif.bus_EN    = 1'b1;
    tick();
    lp0 = l_pulse_cnt;
    tp0 = t_pulse_cnt;
    #2 Reset = 1'b1;
    repeat (8) tick();
    l_q.push_back(8'h3C);
    l_ack = 1'b1;
    t_q.push_back(8'hC3);
    t_ack = 1'b1;
    n_checks++;
    if ((l_pulse_cnt - lp0) != 1 || lif.sync_valid !== 1'b1 || lif.sync_bus !== l_q[0] || lif.ack_out !== l_ack) begin
      n_errors++;
      $display("FAIL post_reset_lvl: pulses=%0d valid=%b bus=%h ack=%b, want 1 1 %h %b",
               l_pulse_cnt - lp0, lif.sync_valid, lif.sync_bus, lif.ack_out, l_q[0], l_ack);
    end
    n_checks++;
    if ((t_pulse_cnt - tp0) != 1 || tif.sync_valid !== 1'b1 || tif.sync_bus !== t_q[0] || tif.ack_out !== t_ack) begin
      n_errors++;
      $display("FAIL post_reset_tgl: pulses=%0d valid=%b bus=%h ack=%b, want 1 1 %h %b",
               t_pulse_cnt - tp0, tif.sync_valid, tif.sync_bus, tif.ack_out, t_q[0], t_ack);
    end
  endtask

  initial begin
    lif.Async_bus  = '0;
    lif.bus_EN     = 1'b0;
    lif.sync_ready = 1'b0;
    tif.Async_bus  = '0;
    tif.bus_EN     = 1'b0;
    tif.sync_ready = 1'b0;
    Reset          = 1'b0;

    test_reset();
    test_level_capture();
    test_toggle_two();
    test_level_overrun();
    test_toggle_pending();
    test_full_push_pop();
    test_random();
    test_reset_mid_stream();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
